inst_encoder: RTL and testbench

Instruction encoder and program loader for the pipelined MIPS core: the inverse of the controller's decode. Accepts one symbolic instruction per handshake and packs it into a 32-bit MIPS word. Writes the encoded words to consecutive instruction-memory addresses through a backpressured write port. Used by self-test and boot-loading logic to build programs in IM without an external assembler.

---
 rtl/inst_enc_pkg.sv | 75 +++++++
 rtl/inst_enc_if.sv | 37 +++
 rtl/inst_enc_core.sv | 60 ++++++
 rtl/inst_encoder.sv | 130 +++++++++++++
 tb/tb_inst_encoder.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/inst_enc_pkg.sv
// Shared types and constants for the MIPS instruction encoder / program loader.
// Optional feature: INST_ENC_ILLEGAL_TRAP_EN (see inst_encoder.sv).
package inst_enc_pkg;

  typedef enum logic [5:0] {
    MN_ADDU, MN_SUBU, MN_ADD,  MN_SUB,  MN_AND,  MN_OR,   MN_XOR,  MN_NOR,
    MN_SLT,  MN_SLTU, MN_SLL,  MN_SRL,  MN_SRA,  MN_SLLV, MN_SRLV, MN_SRAV,
    MN_JR,   MN_JALR,
    MN_ADDI, MN_SLTI, MN_ANDI, MN_ORI,  MN_LUI,
    MN_LB,   MN_LH,   MN_LW,   MN_LBU,  MN_LHU,
    MN_SB,   MN_SH,   MN_SW,
    MN_BEQ,  MN_BNE,  MN_J,    MN_JAL
  } mn_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_e;

  localparam logic [31:0] NOP_WORD = '0;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU   = 6'h25;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_SLLV  = 6'h04;
  localparam logic [5:0] FN_SRLV  = 6'h06;
  localparam logic [5:0] FN_SRAV  = 6'h07;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_JALR  = 6'h09;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SLTU  = 6'h2B;

  function automatic logic [31:0] r_word(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                                         logic [4:0] sh, logic [5:0] fn);
    return {OP_RTYPE, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] i_word(logic [5:0] op, logic [4:0] rs, logic [4:0] rt,
                                         logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] j_word(logic [5:0] op, logic [25:0] target);
    return {op, target};
  endfunction

endpackage

// File: rtl/inst_enc_if.sv
// Symbolic-instruction input stream plus IM write port and status of the loader.
// master = loader/host side, slave = inst_encoder.
interface inst_enc_if #(
  parameter int unsigned AW = 10
) ();
  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic [5:0]    in_mn;
  logic [4:0]    in_rs;
  logic [4:0]    in_rt;
  logic [4:0]    in_rd;
  logic [4:0]    in_shamt;
  logic [15:0]   in_imm;
  logic [25:0]   in_target;
  logic          in_last;
  logic          im_we;
  logic [AW-1:0] im_addr;
  logic [31:0]   im_wdata;
  logic          im_ready;
  logic [AW:0]   count;
  logic          busy;
  logic          done;
  logic          err;

  modport master (
    output start, in_valid, in_mn, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target,
           in_last, im_ready,
    input  in_ready, im_we, im_addr, im_wdata, count, busy, done, err
  );

  modport slave (
    input  start, in_valid, in_mn, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target,
           in_last, im_ready,
    output in_ready, im_we, im_addr, im_wdata, count, busy, done, err
  );
endinterface

// File: rtl/inst_enc_core.sv
// Combinational packer: mnemonic + operand fields -> 32-bit MIPS word and legality flag.
// Fields a mnemonic does not use are forced to zero; unknown mnemonics yield NOP.
module inst_enc_core
  import inst_enc_pkg::*;
(
  input  logic [5:0]  mn,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        legal
);

  always_comb begin
    word  = NOP_WORD;
    legal = 1'b1;
    case (mn_e'(mn))
      MN_ADDU: word = r_word(rs, rt, rd, '0, FN_ADDU);
      MN_SUBU: word = r_word(rs, rt, rd, '0, FN_SUBU);
      MN_ADD:  word = r_word(rs, rt, rd, '0, FN_ADD);
      MN_SUB:  word = r_word(rs, rt, rd, '0, FN_SUB);
      MN_AND:  word = r_word(rs, rt, rd, '0, FN_AND);
      MN_OR:   word = r_word(rs, rt, rd, '0, FN_OR);
      MN_XOR:  word = r_word(rs, rt, rd, '0, FN_XOR);
      MN_NOR:  word = r_word(rs, rt, rd, '0, FN_NOR);
      MN_SLT:  word = r_word(rs, rt, rd, '0, FN_SLT);
      MN_SLTU: word = r_word(rs, rt, rd, '0, FN_SLTU);
      MN_SLL:  word = r_word('0, rt, rd, shamt, FN_SLL);
      MN_SRL:  word = r_word('0, rt, rd, shamt, FN_SRL);
      MN_SRA:  word = r_word('0, rt, rd, shamt, FN_SRA);
      MN_SLLV: word = r_word(rs, rt, rd, '0, FN_SLLV);
      MN_SRLV: word = r_word(rs, rt, rd, '0, FN_SRLV);
      MN_SRAV: word = r_word(rs, rt, rd, '0, FN_SRAV);
      MN_JR:   word = r_word(rs, '0, '0, '0, FN_JR);
      MN_JALR: word = r_word(rs, '0, rd, '0, FN_JALR);
      MN_ADDI: word = i_word(OP_ADDI, rs, rt, imm);
      MN_SLTI: word = i_word(OP_SLTI, rs, rt, imm);
      MN_ANDI: word = i_word(OP_ANDI, rs, rt, imm);
      MN_ORI:  word = i_word(OP_ORI, rs, rt, imm);
      MN_LUI:  word = i_word(OP_LUI, '0, rt, imm);
      MN_LB:   word = i_word(OP_LB, rs, rt, imm);
      MN_LH:   word = i_word(OP_LH, rs, rt, imm);
      MN_LW:   word = i_word(OP_LW, rs, rt, imm);
      MN_LBU:  word = i_word(OP_LBU, rs, rt, imm);
      MN_LHU:  word = i_word(OP_LHU, rs, rt, imm);
      MN_SB:   word = i_word(OP_SB, rs, rt, imm);
      MN_SH:   word = i_word(OP_SH, rs, rt, imm);
      MN_SW:   word = i_word(OP_SW, rs, rt, imm);
      MN_BEQ:  word = i_word(OP_BEQ, rs, rt, imm);
      MN_BNE:  word = i_word(OP_BNE, rs, rt, imm);
      MN_J:    word = j_word(OP_J, target);
      MN_JAL:  word = j_word(OP_JAL, target);
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/inst_encoder.sv
// Program loader: encodes one symbolic instruction per handshake and writes it to
// consecutive IM addresses. Define INST_ENC_ILLEGAL_TRAP_EN to drop illegal mnemonics.
module inst_encoder
  import inst_enc_pkg::*;
#(
  parameter int unsigned AW   = 10,
  parameter int unsigned BASE = 0
) (
  input logic       clk,
  input logic       rst_n,
  inst_enc_if.slave bus
);

  localparam logic [AW-1:0] BASE_ADDR = AW'(BASE);
  localparam logic [AW:0]   DEPTH_CNT = {1'b1, {AW{1'b0}}};

`ifdef INST_ENC_ILLEGAL_TRAP_EN
  localparam logic TRAP_EN = 1'b1;
`else
  localparam logic TRAP_EN = 1'b0;
`endif

  state_e        state_q, state_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] next_q, next_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [AW:0]   count_q, count_d;
  logic          err_q, err_d;

  logic          in_ready;
  logic          done;
  logic          wr_done;
  logic [31:0]   enc_word;
  logic          enc_legal;

  inst_enc_core u_core (
    .mn     (bus.in_mn),
    .rs     (bus.in_rs),
    .rt     (bus.in_rt),
    .rd     (bus.in_rd),
    .shamt  (bus.in_shamt),
    .imm    (bus.in_imm),
    .target (bus.in_target),
    .word   (enc_word),
    .legal  (enc_legal)
  );

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    addr_d   = addr_q;
    next_d   = next_q;
    wdata_d  = wdata_q;
    count_d  = count_q;
    err_d    = err_q;
    in_ready = 1'b0;
    done     = 1'b0;

    wr_done = we_q && bus.im_ready;
    if (wr_done) begin
      we_d    = 1'b0;
      count_d = count_q + 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_RUN;
          next_d  = BASE_ADDR;
          count_d = '0;
          err_d   = 1'b0;
        end
      end
      S_RUN: begin
        in_ready = !we_q || bus.im_ready;
        if (bus.in_valid && in_ready) begin
          // Accept implies the register is empty after this edge, so count_d is
          // the exact number of words committed so far.
          if ((count_d == DEPTH_CNT) || (TRAP_EN && !enc_legal)) begin
            err_d = 1'b1;
          end else begin
            we_d    = 1'b1;
            wdata_d = enc_word;
            addr_d  = next_q;
            next_d  = next_q + 1'b1;
          end
          if (bus.in_last) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!we_q || bus.im_ready) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      addr_q  <= BASE_ADDR;
      next_q  <= BASE_ADDR;
      wdata_q <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      next_q  <= next_d;
      wdata_q <= wdata_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign bus.in_ready = in_ready;
  assign bus.im_we    = we_q;
  assign bus.im_addr  = addr_q;
  assign bus.im_wdata = wdata_q;
  assign bus.count    = count_q;
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.done     = done;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Randomized self-checking bench for inst_encoder (AW=2) with a field-table reference encoder
// and a program-level model of addressing, overflow and illegal handling.
module tb_inst_encoder;
  import inst_enc_pkg::*;

  localparam int unsigned TAW = 2;
  localparam int DEPTH = 4;
  localparam int BASE  = 0;
`ifdef INST_ENC_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  typedef struct {
    logic [5:0]  mn;
    logic [4:0]  rs, rt, rd, sh;
    logic [15:0] imm;
    logic [25:0] tgt;
  } inst_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_checks = 0;
  int n_fail = 0;
  int cyc_ctr = 0;
  int done_cnt = 0;

  inst_t       prog[$];
  int          got_addr[$];
  logic [31:0] got_data[$];
  int          got_cyc[$];
  int          exp_addr[$];
  logic [31:0] exp_data[$];
  int          exp_count;
  bit          exp_err;

  inst_enc_if #(.AW(TAW)) bus ();
  inst_encoder #(.AW(TAW), .BASE(BASE)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc_ctr++;

  always @(negedge clk) begin
    if (rst_n && bus.im_we && bus.im_ready) begin
      got_addr.push_back(int'(bus.im_addr));
      got_data.push_back(bus.im_wdata);
      got_cyc.push_back(cyc_ctr);
    end
    if (rst_n && bus.done) done_cnt++;
  end

  // Reference encoder: opcode/funct plus a per-mnemonic list of which fields survive.
  function automatic logic [31:0] ref_enc(inst_t t, output bit legal);
    int op, fn, fmt;
    bit krs, krt, krd, ksh;
    op = 0; fn = 0; fmt = 0; krs = 1; krt = 1; krd = 1; ksh = 0; legal = 1;
    case (t.mn)
      MN_ADDU: fn = 'h21;  MN_SUBU: fn = 'h23;  MN_ADD: fn = 'h20;  MN_SUB: fn = 'h22;
      MN_AND:  fn = 'h24;  MN_OR:   fn = 'h25;  MN_XOR: fn = 'h26;  MN_NOR: fn = 'h27;
      MN_SLT:  fn = 'h2A;  MN_SLTU: fn = 'h2B;
      MN_SLL:  begin fn = 'h00; krs = 0; ksh = 1; end
      MN_SRL:  begin fn = 'h02; krs = 0; ksh = 1; end
      MN_SRA:  begin fn = 'h03; krs = 0; ksh = 1; end
      MN_SLLV: fn = 'h04;  MN_SRLV: fn = 'h06;  MN_SRAV: fn = 'h07;
      MN_JR:   begin fn = 'h08; krt = 0; krd = 0; end
      MN_JALR: begin fn = 'h09; krt = 0; end
      MN_ADDI: begin fmt = 1; op = 'h08; end
      MN_SLTI: begin fmt = 1; op = 'h0A; end
      MN_ANDI: begin fmt = 1; op = 'h0C; end
      MN_ORI:  begin fmt = 1; op = 'h0D; end
      MN_LUI:  begin fmt = 1; op = 'h0F; krs = 0; end
      MN_LB:   begin fmt = 1; op = 'h20; end
      MN_LH:   begin fmt = 1; op = 'h21; end
      MN_LW:   begin fmt = 1; op = 'h23; end
      MN_LBU:  begin fmt = 1; op = 'h24; end
      MN_LHU:  begin fmt = 1; op = 'h25; end
      MN_SB:   begin fmt = 1; op = 'h28; end
      MN_SH:   begin fmt = 1; op = 'h29; end
      MN_SW:   begin fmt = 1; op = 'h2B; end
      MN_BEQ:  begin fmt = 1; op = 'h04; end
      MN_BNE:  begin fmt = 1; op = 'h05; end
      MN_J:    begin fmt = 2; op = 'h02; end
      MN_JAL:  begin fmt = 2; op = 'h03; end
      default: begin legal = 0; return 32'h0; end
    endcase
    if (fmt == 0)
      return (32'(krs ? t.rs : 5'd0) << 21) + (32'(krt ? t.rt : 5'd0) << 16) +
             (32'(krd ? t.rd : 5'd0) << 11) + (32'(ksh ? t.sh : 5'd0) << 6) + 32'(fn);
    else if (fmt == 1)
      return (32'(op) << 26) + (32'(krs ? t.rs : 5'd0) << 21) + (32'(t.rt) << 16) + 32'(t.imm);
    else
      return (32'(op) << 26) + 32'(t.tgt);
  endfunction

  function automatic void model();
    int written;
    bit legal;
    logic [31:0] w;
    written = 0;
    exp_addr.delete();
    exp_data.delete();
    exp_err = 0;
    foreach (prog[i]) begin
      w = ref_enc(prog[i], legal);
      if (written == DEPTH || (TRAP && !legal)) exp_err = 1;
      else begin
        exp_addr.push_back((BASE + written) % DEPTH);
        exp_data.push_back(w);
        written++;
      end
    end
    exp_count = written;
  endfunction

  function automatic inst_t mk(logic [5:0] mn, int rs, int rt, int rd, int sh, int imm, int tgt);
    inst_t t;
    t.mn = mn; t.rs = 5'(rs); t.rt = 5'(rt); t.rd = 5'(rd); t.sh = 5'(sh);
    t.imm = 16'(imm); t.tgt = 26'(tgt);
    return t;
  endfunction

  function automatic inst_t rand_inst(bit allow_illegal);
    inst_t t;
    if (allow_illegal && $urandom_range(0, 5) == 0) t.mn = 6'($urandom_range(35, 63));
    else t.mn = 6'($urandom_range(0, 34));
    t.rs = 5'($urandom); t.rt = 5'($urandom); t.rd = 5'($urandom); t.sh = 5'($urandom);
    t.imm = 16'($urandom); t.tgt = 26'($urandom);
    return t;
  endfunction

  task automatic drive_inst(inst_t t, bit last);
    bus.in_mn = t.mn; bus.in_rs = t.rs; bus.in_rt = t.rt; bus.in_rd = t.rd;
    bus.in_shamt = t.sh; bus.in_imm = t.imm; bus.in_target = t.tgt; bus.in_last = last;
  endtask

  task automatic clear_capture();
    got_addr.delete(); got_data.delete(); got_cyc.delete(); done_cnt = 0;
  endtask

  // Loads prog; fast = valid and im_ready held high, otherwise random gaps, stalls and stray starts.
  task automatic run_prog(bit fast);
    int idx, cyc;
    bit fin;
    clear_capture();
    bus.in_valid = 0; bus.start = 1;
    @(posedge clk); #1;
    bus.start = 0;
    idx = 0; fin = 0; cyc = 0;
    while (!fin && cyc < 400) begin
      if (idx < prog.size()) begin
        drive_inst(prog[idx], idx == prog.size() - 1);
        bus.in_valid = fast || ($urandom_range(0, 3) != 0);
      end else bus.in_valid = 0;
      bus.im_ready = fast || ($urandom_range(0, 2) != 0);
      if (!fast) bus.start = ($urandom_range(0, 7) == 0);
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) idx++;
      if (bus.done) fin = 1;
      else begin @(posedge clk); #1; end
      cyc++;
    end
    bus.start = 0; bus.in_valid = 0;
    if (!fin) begin
      n_checks++; n_fail++;
      $display("FAIL run_timeout: done=%0b after %0d cycles, required done=1", bus.done, cyc);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    bus.start = 0; bus.in_valid = 0; bus.im_ready = 0;
    drive_inst(mk(6'd0, 0, 0, 0, 0, 0, 0), 0);
    rst_n = 0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus.in_ready, bus.im_we, bus.im_addr, bus.im_wdata, bus.count, bus.busy, bus.done, bus.err}
        !== {1'b0, 1'b0, TAW'(BASE), 32'h0, 3'h0, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_values: got rdy=%0b we=%0b addr=%0d wdata=%h count=%0d busy=%0b done=%0b err=%0b required all zero",
               bus.in_ready, bus.im_we, bus.im_addr, bus.im_wdata, bus.count, bus.busy, bus.done, bus.err);
    end
    @(negedge clk); rst_n = 1;
    bus.in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.in_ready !== 1'b0 || bus.busy !== 1'b0 || bus.im_we !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_no_accept: got rdy=%0b busy=%0b we=%0b required 0 0 0", bus.in_ready, bus.busy, bus.im_we);
      end
    end
    bus.in_valid = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    prog.delete();
    prog.push_back(mk(MN_ADDU, 1, 2, 3, 7, 0, 0));
    run_prog(1);
    n_checks++;
    if (got_data.size() != 1) begin n_fail++; $display("FAIL single_nwrites: got %0d required 1", got_data.size()); end
    n_checks++;
    if (got_data[0] !== 32'h00221821 || got_addr[0] !== 0) begin
      n_fail++; $display("FAIL single_word: got %h@%0d required 00221821@0", got_data[0], got_addr[0]);
    end
    n_checks++;
    if (done_cnt !== 1 || bus.count !== 3'd1 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL single_status: got done_pulses=%0d count=%0d busy=%0b required 1 1 0", done_cnt, bus.count, bus.busy);
    end
  endtask

  task automatic test_stream();
    logic [31:0] want[3];
    want[0] = 32'h34081234; want[1] = 32'hAFA20004; want[2] = 32'h08000010;
    prog.delete();
    prog.push_back(mk(MN_ORI, 0, 8, 0, 0, 'h1234, 0));
    prog.push_back(mk(MN_SW, 29, 2, 0, 0, 4, 0));
    prog.push_back(mk(MN_J, 0, 0, 0, 0, 0, 'h10));
    run_prog(1);
    n_checks++;
    if (got_data.size() != 3) begin n_fail++; $display("FAIL stream_nwrites: got %0d required 3", got_data.size()); end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (got_data[i] !== want[i] || got_addr[i] !== i) begin
        n_fail++; $display("FAIL stream_word%0d: got %h@%0d required %h@%0d", i, got_data[i], got_addr[i], want[i], i);
      end
    end
    for (int i = 1; i < 3; i++) begin
      n_checks++;
      if (got_cyc[i] !== got_cyc[0] + i) begin
        n_fail++; $display("FAIL stream_b2b%0d: got cycle %0d required %0d", i, got_cyc[i], got_cyc[0] + i);
      end
    end
  endtask

  task automatic test_fields();
    prog.delete();
    prog.push_back(mk(MN_SLL, 9, 5, 4, 2, 0, 0));
    prog.push_back(mk(MN_LUI, 5, 1, 0, 0, 'hFFFF, 0));
    run_prog(1);
    n_checks++;
    if (got_data.size() != 2 || got_data[0] !== 32'h00052080) begin
      n_fail++; $display("FAIL fields_sll: got %h (n=%0d) required 00052080", got_data[0], got_data.size());
    end
    n_checks++;
    if (got_data[1] !== 32'h3C01FFFF) begin
      n_fail++; $display("FAIL fields_lui: got %h required 3c01ffff", got_data[1]);
    end
  endtask

  task automatic test_stall();
    inst_t a, b, c;
    logic [31:0] wa, wb, wc;
    bit lg;
    a = rand_inst(0); b = rand_inst(0); c = rand_inst(0);
    wa = ref_enc(a, lg); wb = ref_enc(b, lg); wc = ref_enc(c, lg);
    clear_capture();
    bus.start = 1; @(posedge clk); #1; bus.start = 0;
    drive_inst(a, 0); bus.in_valid = 1; bus.im_ready = 1;
    @(posedge clk); #1;
    drive_inst(b, 0); bus.im_ready = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.in_ready !== 1'b0 || bus.im_we !== 1'b1 || bus.im_addr !== 2'd0 || bus.im_wdata !== wa) begin
        n_fail++;
        $display("FAIL stall_hold%0d: got rdy=%0b we=%0b %h@%0d required rdy=0 we=1 %h@0",
                 i, bus.in_ready, bus.im_we, bus.im_wdata, bus.im_addr, wa);
      end
    end
    @(posedge clk); #1; bus.im_ready = 1;
    @(negedge clk);
    n_checks++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_release: got rdy=%0b required 1", bus.in_ready); end
    @(posedge clk); #1; drive_inst(c, 1);
    @(posedge clk); #1; bus.in_valid = 0;
    for (int k = 0; k < 10 && done_cnt == 0; k++) @(posedge clk);
    #1;
    n_checks++;
    if (got_data.size() != 3 || done_cnt !== 1) begin
      n_fail++; $display("FAIL stall_nwrites: got %0d writes %0d done required 3 writes 1 done", got_data.size(), done_cnt);
    end
    n_checks++;
    if (got_data[0] !== wa || got_data[1] !== wb || got_data[2] !== wc ||
        got_addr[0] !== 0 || got_addr[1] !== 1 || got_addr[2] !== 2) begin
      n_fail++; $display("FAIL stall_order: got %h %h %h required %h %h %h", got_data[0], got_data[1], got_data[2], wa, wb, wc);
    end
  endtask

  task automatic test_overflow();
    prog.delete();
    for (int i = 0; i < 5; i++) prog.push_back(rand_inst(0));
    model();
    run_prog(1);
    n_checks++;
    if (got_data.size() != 4) begin n_fail++; $display("FAIL ovf_nwrites: got %0d required 4", got_data.size()); end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (got_data[i] !== exp_data[i] || got_addr[i] !== i) begin
        n_fail++; $display("FAIL ovf_word%0d: got %h@%0d required %h@%0d", i, got_data[i], got_addr[i], exp_data[i], i);
      end
    end
    n_checks++;
    if (bus.err !== 1'b1 || bus.count !== 3'd4 || done_cnt !== 1) begin
      n_fail++; $display("FAIL ovf_status: got err=%0b count=%0d done_pulses=%0d required 1 4 1", bus.err, bus.count, done_cnt);
    end
  endtask

  task automatic test_illegal();
    prog.delete();
    prog.push_back(mk(MN_ADDU, 4, 5, 6, 0, 0, 0));
    prog.push_back(mk(6'h3F, 1, 2, 3, 4, 'h55, 'h77));
    prog.push_back(mk(MN_ORI, 7, 8, 0, 0, 'hBEEF, 0));
    model();
    run_prog(1);
    n_checks++;
    if (got_data.size() != exp_data.size()) begin
      n_fail++; $display("FAIL illegal_nwrites: got %0d required %0d", got_data.size(), exp_data.size());
    end
    foreach (exp_data[i]) begin
      n_checks++;
      if (got_data[i] !== exp_data[i] || got_addr[i] !== exp_addr[i]) begin
        n_fail++; $display("FAIL illegal_word%0d: got %h@%0d required %h@%0d", i, got_data[i], got_addr[i], exp_data[i], exp_addr[i]);
      end
    end
    n_checks++;
    if (bus.err !== exp_err || int'(bus.count) !== exp_count) begin
      n_fail++; $display("FAIL illegal_status: got err=%0b count=%0d required %0b %0d", bus.err, bus.count, exp_err, exp_count);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 10; r++) begin
      prog.delete();
      for (int i = 0, n = $urandom_range(1, 6); i < n; i++) prog.push_back(rand_inst(1));
      model();
      run_prog(0);
      n_checks++;
      if (got_data.size() != exp_data.size()) begin
        n_fail++; $display("FAIL rand%0d_nwrites: got %0d required %0d", r, got_data.size(), exp_data.size());
      end
      foreach (exp_data[i]) begin
        n_checks++;
        if (got_data[i] !== exp_data[i] || got_addr[i] !== exp_addr[i]) begin
          n_fail++; $display("FAIL rand%0d_word%0d: got %h@%0d required %h@%0d", r, i, got_data[i], got_addr[i], exp_data[i], exp_addr[i]);
        end
      end
      n_checks++;
      if (bus.err !== exp_err || int'(bus.count) !== exp_count || done_cnt !== 1 || bus.busy !== 1'b0) begin
        n_fail++;
        $display("FAIL rand%0d_status: got err=%0b count=%0d done_pulses=%0d busy=%0b required %0b %0d 1 0",
                 r, bus.err, bus.count, done_cnt, bus.busy, exp_err, exp_count);
      end
    end
  endtask

  task automatic test_reset_mid();
    clear_capture();
    bus.start = 1; @(posedge clk); #1; bus.start = 0;
    drive_inst(rand_inst(0), 0); bus.in_valid = 1; bus.im_ready = 0;
    @(posedge clk); #1;
    drive_inst(rand_inst(0), 0);
    @(negedge clk); #2;
    rst_n = 0;
    #1;
    n_checks++;
    if ({bus.in_ready, bus.im_we, bus.im_addr, bus.im_wdata, bus.count, bus.busy, bus.done, bus.err}
        !== {1'b0, 1'b0, TAW'(BASE), 32'h0, 3'h0, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL midreset_values: got rdy=%0b we=%0b addr=%0d wdata=%h count=%0d busy=%0b required all zero",
               bus.in_ready, bus.im_we, bus.im_addr, bus.im_wdata, bus.count, bus.busy);
    end
    bus.in_valid = 0; bus.im_ready = 1;
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.im_we !== 1'b0 || got_data.size() != 0) begin
      n_fail++; $display("FAIL midreset_after: got busy=%0b we=%0b writes=%0d required 0 0 0", bus.busy, bus.im_we, got_data.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_fields();
    test_stall();
    test_overflow();
    test_illegal();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
